// File: rtl/rf_tdd_seq.sv
// -----------------------------------------------------------------------------
// rf_tdd_seq -- TDD RF front-end GPIO sequencer
//
// A frame is a table of NUM_PHASES phases. Each phase has its own duration in
// clock cycles and its own GPIO word. A rising edge on trig starts a frame.
// Phases with zero duration are skipped. Frames repeat back to back unless
// single_shot is set. The configuration is captured into shadow registers on
// each trig edge and again at every frame boundary, so software can rewrite
// cfg_* while a frame is running without tearing it.
//
// Optional feature, guarded by the macro RF_TDD_ROT_EN: phase ROT_PHASE takes
// its GPIO word from a rotation table indexed by rot_idx. rot_idx steps once
// per completed frame. When the macro is not defined, cfg_rot_gpio and
// cfg_rot_len are accepted but ignored.
//
// Ports
//   clk, rst_n     clock; asynchronous active-low reset
//   trig           frame sync; its rising edge (re)starts a frame
//   enable         low forces IDLE on the next cycle
//   single_shot    1: one frame per trig edge; 0: free-run
//   cfg_dur        phase p duration, slice p (CNT_W bits each)
//   cfg_gpio       phase p GPIO word, slice p (GPIO_W bits each)
//   cfg_idle_gpio  GPIO word driven while IDLE
//   cfg_rot_gpio   rotation table (ROT_DEPTH words)
//   cfg_rot_len    active rotation entries (0 behaves as 1)
//   gpio_out       registered GPIO word
//   phase_idx      current phase (0 in IDLE)
//   running        FSM state: high in RUN, low in IDLE
//   frame_cnt      frames completed since the last trig edge
//   frame_pulse    one cycle high in the first cycle after a frame completes
//   resync         one cycle high when trig restarts a running frame
//   cfg_err        set when a start finds every duration zero; cleared by trig
// -----------------------------------------------------------------------------
module rf_tdd_seq #(
   parameter int NUM_PHASES = 5,
   parameter int GPIO_W     = 32,
   parameter int CNT_W      = 24,
   parameter int ROT_DEPTH  = 10,
   parameter int ROT_PHASE  = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         trig,
   input  logic                         enable,
   input  logic                         single_shot,
   input  logic [NUM_PHASES*CNT_W-1:0]  cfg_dur,
   input  logic [NUM_PHASES*GPIO_W-1:0] cfg_gpio,
   input  logic [GPIO_W-1:0]            cfg_idle_gpio,
   input  logic [ROT_DEPTH*GPIO_W-1:0]  cfg_rot_gpio,
   input  logic [3:0]                   cfg_rot_len,
   output logic [GPIO_W-1:0]            gpio_out,
   output logic [3:0]                   phase_idx,
   output logic                         running,
   output logic [15:0]                  frame_cnt,
   output logic                         frame_pulse,
   output logic                         resync,
   output logic                         cfg_err
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t            state_q, state_nx;
   logic              trig_d;
   logic              trig_start;
   logic [3:0]        phase_q, phase_nx;
   logic [CNT_W-1:0]  cnt_q, cnt_nx;
   logic [15:0]       frame_cnt_nx;
   logic              pulse_nx, resync_nx, cfg_err_nx;
   logic [GPIO_W-1:0] gpio_nx;
   logic              load;

   // Live configuration split into per-phase words.
   logic [CNT_W-1:0]  cfg_dur_a  [NUM_PHASES];
   logic [GPIO_W-1:0] cfg_gpio_a [NUM_PHASES];

   // Shadow copy used while a frame runs.
   logic [CNT_W-1:0]  sh_dur  [NUM_PHASES];
   logic [GPIO_W-1:0] sh_gpio [NUM_PHASES];

   // Phase search results.
   logic              cfg_any;
   logic [3:0]        first_nz;
   logic              has_next;
   logic [3:0]        next_nz;
   logic [CNT_W-1:0]  cur_dur;
   logic              phase_end;

   for (genvar g = 0; g < NUM_PHASES; g++) begin : g_unpack
      assign cfg_dur_a[g]  = cfg_dur[g*CNT_W +: CNT_W];
      assign cfg_gpio_a[g] = cfg_gpio[g*GPIO_W +: GPIO_W];
   end

`ifdef RF_TDD_ROT_EN
   logic [GPIO_W-1:0] cfg_rot_a [ROT_DEPTH];
   logic [GPIO_W-1:0] sh_rot    [ROT_DEPTH];
   logic [3:0]        sh_rot_len;
   logic [3:0]        rot_idx_q, rot_idx_nx;
   logic [3:0]        rot_last;

   for (genvar g = 0; g < ROT_DEPTH; g++) begin : g_rot_unpack
      assign cfg_rot_a[g] = cfg_rot_gpio[g*GPIO_W +: GPIO_W];
   end

   // Last valid rotation index. A length of 0 behaves as 1, and lengths
   // beyond the table depth are clipped to the table.
   always_comb begin
      rot_last = 4'd0;
      if (sh_rot_len != 4'd0) begin
         rot_last = sh_rot_len - 4'd1;
      end
      if (rot_last > 4'(ROT_DEPTH - 1)) begin
         rot_last = 4'(ROT_DEPTH - 1);
      end
   end
`else
   logic unused_rot;
   assign unused_rot = ^{cfg_rot_gpio, cfg_rot_len, 4'(ROT_PHASE)};
`endif

   assign trig_start = trig & ~trig_d;
   assign running    = (state_q == S_RUN);
   assign phase_idx  = phase_q;

   // First non-zero phase of the live configuration (used on every (re)start,
   // because the shadow is reloaded in the same cycle), and the next non-zero
   // phase after the current one in the shadow. Descending loops let the
   // lowest matching index win.
   always_comb begin
      cfg_any  = 1'b0;
      first_nz = 4'd0;
      has_next = 1'b0;
      next_nz  = 4'd0;
      cur_dur  = '0;
      for (int i = NUM_PHASES - 1; i >= 0; i--) begin
         if (cfg_dur_a[i] != '0) begin
            cfg_any  = 1'b1;
            first_nz = 4'(i);
         end
         if ((4'(i) > phase_q) && (sh_dur[i] != '0)) begin
            has_next = 1'b1;
            next_nz  = 4'(i);
         end
         if (phase_q == 4'(i)) begin
            cur_dur = sh_dur[i];
         end
      end
   end

   assign phase_end = (cnt_q == (cur_dur - CNT_ONE));

   // Next-state logic. Priority: enable low, then trig edge, then counting.
   always_comb begin
      state_nx     = state_q;
      phase_nx     = phase_q;
      cnt_nx       = cnt_q;
      frame_cnt_nx = frame_cnt;
      cfg_err_nx   = cfg_err;
      pulse_nx     = 1'b0;
      resync_nx    = 1'b0;
      load         = 1'b0;
`ifdef RF_TDD_ROT_EN
      rot_idx_nx   = rot_idx_q;
`endif
      if (!enable) begin
         state_nx = S_IDLE;
         phase_nx = 4'd0;
      end else if (trig_start) begin
         load         = 1'b1;
         cnt_nx       = '0;
         frame_cnt_nx = 16'd0;
         cfg_err_nx   = ~cfg_any;
         resync_nx    = (state_q == S_RUN);
`ifdef RF_TDD_ROT_EN
         rot_idx_nx   = 4'd0;
`endif
         if (cfg_any) begin
            state_nx = S_RUN;
            phase_nx = first_nz;
         end else begin
            state_nx = S_IDLE;
            phase_nx = 4'd0;
         end
      end else if (state_q == S_RUN) begin
         if (!phase_end) begin
            cnt_nx = cnt_q + CNT_ONE;
         end else begin
            cnt_nx = '0;
            if (has_next) begin
               phase_nx = next_nz;
            end else begin
               // Frame complete.
               load         = 1'b1;
               pulse_nx     = 1'b1;
               frame_cnt_nx = frame_cnt + 16'd1;
`ifdef RF_TDD_ROT_EN
               rot_idx_nx   = (rot_idx_q >= rot_last) ? 4'd0 : rot_idx_q + 4'd1;
`endif
               if (single_shot || !cfg_any) begin
                  state_nx   = S_IDLE;
                  phase_nx   = 4'd0;
                  cfg_err_nx = cfg_err | ~cfg_any;
               end else begin
                  phase_nx = first_nz;
               end
            end
         end
      end
   end

   // GPIO word for the next cycle. When the shadow is being reloaded this
   // cycle, the word comes straight from the live configuration so the first
   // cycle of a frame already shows the new value.
   always_comb begin
      gpio_nx = cfg_idle_gpio;
      if (state_nx == S_RUN) begin
         for (int i = 0; i < NUM_PHASES; i++) begin
            if (phase_nx == 4'(i)) begin
               gpio_nx = load ? cfg_gpio_a[i] : sh_gpio[i];
            end
         end
`ifdef RF_TDD_ROT_EN
         if (phase_nx == 4'(ROT_PHASE)) begin
            for (int j = 0; j < ROT_DEPTH; j++) begin
               if (rot_idx_nx == 4'(j)) begin
                  gpio_nx = load ? cfg_rot_a[j] : sh_rot[j];
               end
            end
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         trig_d      <= 1'b0;
         phase_q     <= 4'd0;
         cnt_q       <= '0;
         gpio_out    <= '0;
         frame_cnt   <= 16'd0;
         frame_pulse <= 1'b0;
         resync      <= 1'b0;
         cfg_err     <= 1'b0;
      end else begin
         state_q     <= state_nx;
         trig_d      <= trig;
         phase_q     <= phase_nx;
         cnt_q       <= cnt_nx;
         gpio_out    <= gpio_nx;
         frame_cnt   <= frame_cnt_nx;
         frame_pulse <= pulse_nx;
         resync      <= resync_nx;
         cfg_err     <= cfg_err_nx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_PHASES; i++) begin
            sh_dur[i]  <= '0;
            sh_gpio[i] <= '0;
         end
      end else if (load) begin
         for (int i = 0; i < NUM_PHASES; i++) begin
            sh_dur[i]  <= cfg_dur_a[i];
            sh_gpio[i] <= cfg_gpio_a[i];
         end
      end
   end

`ifdef RF_TDD_ROT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rot_idx_q  <= 4'd0;
         sh_rot_len <= 4'd0;
         for (int j = 0; j < ROT_DEPTH; j++) begin
            sh_rot[j] <= '0;
         end
      end else begin
         rot_idx_q <= rot_idx_nx;
         if (load) begin
            sh_rot_len <= cfg_rot_len;
            for (int j = 0; j < ROT_DEPTH; j++) begin
               sh_rot[j] <= cfg_rot_a[j];
            end
         end
      end
   end
`endif

endmodule
